// File: rtl/pe_pkg.sv
// Shared definitions for the SAD processing-element array.
// Holds the controller state encoding, the default geometry constants
// and a constant-evaluable ceiling-log2 helper used to size counters,
// accumulators and the best-lane index.
package pe_pkg;

    localparam int PIX_W_DEF   = 8;
    localparam int LANES_DEF   = 4;
    localparam int BLK_PIX_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACC    = 3'd1,
        ST_DRAIN1 = 3'd2,
        ST_DRAIN2 = 3'd3,
        ST_DONE   = 3'd4
    } pe_state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if (value > (32'sd1 <<< i)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_lane.sv
// One candidate lane of the SAD array.
// Stage 1 captures the current/previous pixels (current pixel can be held
// with keep), stage 2 forms the absolute difference, stage 3 accumulates it.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clr          start of a new block: drops in-flight tags, zeroes the sum
//   accept       a beat is accepted this cycle
//   keep         hold the current-pixel register on this beat
//   crt_pix      current-block pixel for this lane
//   pre_pix      candidate (previous-frame) pixel for this lane
//   crt_q/pre_q  stage-1 registers, ad_q stage-2 register, sad_q accumulator
module pe_lane #(
    parameter int PIX_W = 8,
    parameter int SAD_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             accept,
    input  logic             keep,
    input  logic [PIX_W-1:0] crt_pix,
    input  logic [PIX_W-1:0] pre_pix,
    output logic [PIX_W-1:0] crt_q,
    output logic [PIX_W-1:0] pre_q,
    output logic [PIX_W-1:0] ad_q,
    output logic [SAD_W-1:0] sad_q
);

    logic [PIX_W-1:0] crt_r;
    logic [PIX_W-1:0] pre_r;
    logic [PIX_W-1:0] ad_r;
    logic [PIX_W-1:0] ad_s;
    logic [SAD_W-1:0] acc_r;
    logic             s1_valid_r;
    logic             s2_valid_r;

    // Stage 1: capture lane pixels on an accepted beat; the current pixel
    // survives a new block so one reference block can serve many candidates.
    always_ff @(posedge clk) begin
        if (rst) begin
            crt_r      <= {PIX_W{1'b0}};
            pre_r      <= {PIX_W{1'b0}};
            s1_valid_r <= 1'b0;
        end else if (clr) begin
            s1_valid_r <= 1'b0;
        end else if (accept) begin
            pre_r      <= pre_pix;
            if (!keep) begin
                crt_r <= crt_pix;
            end else begin
                crt_r <= crt_r;
            end
            s1_valid_r <= 1'b1;
        end else begin
            s1_valid_r <= 1'b0;
        end
    end

    // Unsigned absolute difference of the stage-1 pixels.
    always_comb begin
        ad_s = {PIX_W{1'b0}};
        if (crt_r >= pre_r) begin
            ad_s = crt_r - pre_r;
        end else begin
            ad_s = pre_r - crt_r;
        end
    end

    // Stage 2: register the difference only for a real beat so idle cycles
    // leave the cascade output untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            ad_r       <= {PIX_W{1'b0}};
            s2_valid_r <= 1'b0;
        end else if (clr) begin
            s2_valid_r <= 1'b0;
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                ad_r <= ad_s;
            end else begin
                ad_r <= ad_r;
            end
        end
    end

    // Stage 3: sum of absolute differences; width covers the worst case.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {SAD_W{1'b0}};
        end else if (clr) begin
            acc_r <= {SAD_W{1'b0}};
        end else if (s2_valid_r) begin
            acc_r <= acc_r + SAD_W'(ad_r);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign crt_q = crt_r;
    assign pre_q = pre_r;
    assign ad_q  = ad_r;
    assign sad_q = acc_r;

endmodule

// File: rtl/pe_sad_array.sv
// Parallel sum-of-absolute-differences array: LANES candidate lanes share
// one beat handshake, accumulate BLK_PIX beats, then report per-lane SADs
// and the lowest-SAD lane (ties to the lowest index).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i                  begin a block (honoured only when idle)
//   in_valid_i / in_ready_o  beat handshake (ready only while accumulating)
//   crt_keep                 hold current-pixel registers for this beat
//   crt_pixel_i, pre_pixel_i lane pixels, lane k at [k*PIX_W +: PIX_W]
//   crt_pixel_o, pre_pixel_o stage-1 lane registers; ad_o stage-2 registers
//   sad_valid_o              one-cycle pulse when sad_o is final
//   sad_o                    per-lane SAD, lane k at [k*SAD_W +: SAD_W]
//   best_idx_o, best_sad_o   argmin lane and its SAD
//   busy_o                   block in progress
module pe_sad_array
    import pe_pkg::*;
#(
    parameter  int PIX_W   = PIX_W_DEF,
    parameter  int LANES   = LANES_DEF,
    parameter  int BLK_PIX = BLK_PIX_DEF,
    localparam int SAD_W   = PIX_W + clog2(BLK_PIX),
    localparam int IDX_W   = clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   crt_keep,
    input  logic [LANES*PIX_W-1:0] crt_pixel_i,
    input  logic [LANES*PIX_W-1:0] pre_pixel_i,
    output logic [LANES*PIX_W-1:0] crt_pixel_o,
    output logic [LANES*PIX_W-1:0] pre_pixel_o,
    output logic [LANES*PIX_W-1:0] ad_o,
    output logic                   sad_valid_o,
    output logic [LANES*SAD_W-1:0] sad_o,
    output logic [IDX_W-1:0]       best_idx_o,
    output logic [SAD_W-1:0]       best_sad_o,
    output logic                   busy_o
);

    localparam int CNT_W = (clog2(BLK_PIX) < 1) ? 1 : clog2(BLK_PIX);

    pe_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             sad_valid_r;
    logic             clr_s;
    logic             accept_s;
    logic [SAD_W-1:0] lane_sad_s [LANES];
    logic [IDX_W-1:0] best_idx_s;
    logic [SAD_W-1:0] best_sad_s;

    assign clr_s    = (state_r == ST_IDLE) && start_i;
    assign accept_s = in_ready_r && in_valid_i;

    // Block controller: beat counting, fixed drain to cover the two pipeline
    // stages behind the last beat, and registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            sad_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sad_valid_r <= 1'b0;
                    if (start_i) begin
                        state_r    <= ST_ACC;
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_ACC: begin
                    if (in_valid_i) begin
                        if (cnt_r == CNT_W'(BLK_PIX - 1)) begin
                            state_r    <= ST_DRAIN1;
                            cnt_r      <= {CNT_W{1'b0}};
                            in_ready_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_DRAIN1: begin
                    state_r <= ST_DRAIN2;
                end
                ST_DRAIN2: begin
                    state_r     <= ST_DONE;
                    sad_valid_r <= 1'b1;
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    sad_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    in_ready_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    sad_valid_r <= 1'b0;
                end
            endcase
        end
    end

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            pe_lane #(
                .PIX_W (PIX_W),
                .SAD_W (SAD_W)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .clr     (clr_s),
                .accept  (accept_s),
                .keep    (crt_keep),
                .crt_pix (crt_pixel_i[k*PIX_W +: PIX_W]),
                .pre_pix (pre_pixel_i[k*PIX_W +: PIX_W]),
                .crt_q   (crt_pixel_o[k*PIX_W +: PIX_W]),
                .pre_q   (pre_pixel_o[k*PIX_W +: PIX_W]),
                .ad_q    (ad_o[k*PIX_W +: PIX_W]),
                .sad_q   (lane_sad_s[k])
            );
            assign sad_o[k*SAD_W +: SAD_W] = lane_sad_s[k];
        end
    endgenerate

    // Argmin over the accumulator registers; strict compare keeps the
    // lowest index on ties.
    always_comb begin
        best_idx_s = {IDX_W{1'b0}};
        best_sad_s = lane_sad_s[0];
        for (int i = 1; i < LANES; i++) begin
            if (lane_sad_s[i] < best_sad_s) begin
                best_idx_s = IDX_W'(i);
                best_sad_s = lane_sad_s[i];
            end else begin
                best_idx_s = best_idx_s;
            end
        end
    end

    assign in_ready_o  = in_ready_r;
    assign busy_o      = busy_r;
    assign sad_valid_o = sad_valid_r;
    assign best_idx_o  = best_idx_s;
    assign best_sad_o  = best_sad_s;

endmodule

// File: tb/tb_pe_sad_array.sv
module tb_pe_sad_array;

    localparam int PIX_W   = 8;
    localparam int LANES   = 4;
    localparam int BLK_PIX = 16;
    localparam int SAD_W   = 12;
    localparam int IDX_W   = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic                   crt_keep;
    logic [LANES*PIX_W-1:0] crt_pixel_i;
    logic [LANES*PIX_W-1:0] pre_pixel_i;
    logic [LANES*PIX_W-1:0] crt_pixel_o;
    logic [LANES*PIX_W-1:0] pre_pixel_o;
    logic [LANES*PIX_W-1:0] ad_o;
    logic                   sad_valid_o;
    logic [LANES*SAD_W-1:0] sad_o;
    logic [IDX_W-1:0]       best_idx_o;
    logic [SAD_W-1:0]       best_sad_o;
    logic                   busy_o;

    always #5 clk = ~clk;

    pe_sad_array #(.PIX_W(PIX_W), .LANES(LANES), .BLK_PIX(BLK_PIX)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .crt_keep    (crt_keep),
        .crt_pixel_i (crt_pixel_i),
        .pre_pixel_i (pre_pixel_i),
        .crt_pixel_o (crt_pixel_o),
        .pre_pixel_o (pre_pixel_o),
        .ad_o        (ad_o),
        .sad_valid_o (sad_valid_o),
        .sad_o       (sad_o),
        .best_idx_o  (best_idx_o),
        .best_sad_o  (best_sad_o),
        .busy_o      (busy_o)
    );

    int checks = 0;
    int errors = 0;

    // beat tables for the next block, and the model of the current-pixel registers
    int b_crt  [BLK_PIX][LANES];
    int b_pre  [BLK_PIX][LANES];
    bit b_keep [BLK_PIX];
    int m_crt  [LANES];

    task automatic fill_uniform(input int crt_v[LANES], input int pre_v[LANES]);
        for (int b = 0; b < BLK_PIX; b++) begin
            b_keep[b] = 1'b0;
            for (int k = 0; k < LANES; k++) begin
                b_crt[b][k] = crt_v[k];
                b_pre[b][k] = pre_v[k];
            end
        end
    endtask

    // Run one full block; the model sums |crt - pre| per lane with keep semantics.
    task automatic run_block(input string name, input bit gaps, input bit noise);
        int exp_sad [LANES];
        int last_ad [LANES];
        int last_pre[LANES];
        int d;
        int lat;
        int best_i;
        int best_v;
        for (int k = 0; k < LANES; k++) exp_sad[k] = 0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_enter_acc: busy=%b ready=%b, expected 1 1", name, busy_o, in_ready_o);
        end
        for (int b = 0; b < BLK_PIX; b++) begin
            if (gaps) begin
                in_valid_i  = 1'b0;
                crt_keep    = 1'($urandom);
                crt_pixel_i = $urandom;
                pre_pixel_i = $urandom;
                start_i     = noise;
                @(posedge clk); #1;
                start_i = 1'b0;
            end
            crt_keep = b_keep[b];
            for (int k = 0; k < LANES; k++) begin
                crt_pixel_i[k*PIX_W +: PIX_W] = PIX_W'(b_crt[b][k]);
                pre_pixel_i[k*PIX_W +: PIX_W] = PIX_W'(b_pre[b][k]);
            end
            start_i    = noise;
            in_valid_i = 1'b1;
            @(posedge clk); #1;
            in_valid_i = 1'b0;
            start_i    = 1'b0;
            for (int k = 0; k < LANES; k++) begin
                if (!b_keep[b]) m_crt[k] = b_crt[b][k];
                d = m_crt[k] - b_pre[b][k];
                if (d < 0) d = -d;
                exp_sad[k] += d;
                last_ad[k]  = d;
                last_pre[k] = b_pre[b][k];
            end
        end
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_drop: ready=%b, expected 0", name, in_ready_o);
        end
        // beats offered while draining must be ignored
        in_valid_i  = noise;
        crt_keep    = 1'b0;
        crt_pixel_i = $urandom;
        pre_pixel_i = $urandom;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (sad_valid_o === 1'b1) break;
        end
        in_valid_i = 1'b0;
        checks++;
        if (lat != 2 || sad_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: edges after last beat=%0d valid=%b, expected 2 1", name, lat, sad_valid_o);
        end
        best_i = 0;
        best_v = exp_sad[0];
        for (int k = 1; k < LANES; k++) begin
            if (exp_sad[k] < best_v) begin
                best_v = exp_sad[k];
                best_i = k;
            end
        end
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if (sad_o[k*SAD_W +: SAD_W] !== SAD_W'(exp_sad[k])) begin
                errors++;
                $display("FAIL %s_sad_lane%0d: got %0d, expected %0d", name, k, sad_o[k*SAD_W +: SAD_W], exp_sad[k]);
            end
            checks++;
            if (crt_pixel_o[k*PIX_W +: PIX_W] !== PIX_W'(m_crt[k]) ||
                pre_pixel_o[k*PIX_W +: PIX_W] !== PIX_W'(last_pre[k]) ||
                ad_o[k*PIX_W +: PIX_W] !== PIX_W'(last_ad[k])) begin
                errors++;
                $display("FAIL %s_cascade_lane%0d: crt/pre/ad got %0d/%0d/%0d, expected %0d/%0d/%0d",
                         name, k, crt_pixel_o[k*PIX_W +: PIX_W], pre_pixel_o[k*PIX_W +: PIX_W],
                         ad_o[k*PIX_W +: PIX_W], m_crt[k], last_pre[k], last_ad[k]);
            end
        end
        checks++;
        if (best_idx_o !== IDX_W'(best_i) || best_sad_o !== SAD_W'(best_v)) begin
            errors++;
            $display("FAIL %s_best: got idx %0d sad %0d, expected idx %0d sad %0d", name, best_idx_o, best_sad_o, best_i, best_v);
        end
        @(posedge clk); #1;
        checks++;
        if (sad_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_single_pulse: valid=%b busy=%b, expected 0 0", name, sad_valid_o, busy_o);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sad_o[0 +: SAD_W] !== SAD_W'(exp_sad[0]) || best_sad_o !== SAD_W'(best_v)) begin
            errors++;
            $display("FAIL %s_hold: lane0 %0d best %0d, expected %0d %0d", name, sad_o[0 +: SAD_W], best_sad_o, exp_sad[0], best_v);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (crt_pixel_o !== '0 || pre_pixel_o !== '0 || ad_o !== '0 || sad_o !== '0 ||
            best_idx_o !== '0 || best_sad_o !== '0 || sad_valid_o !== 1'b0 ||
            busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: crt=%h pre=%h ad=%h sad=%h idx=%0d best=%0d v=%b busy=%b rdy=%b, expected all 0",
                     name, crt_pixel_o, pre_pixel_o, ad_o, sad_o, best_idx_o, best_sad_o,
                     sad_valid_o, busy_o, in_ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < LANES; k++) m_crt[k] = 0;
        check_all_zero("reset");
    endtask

    task automatic test_max();
        fill_uniform('{0, 0, 0, 0}, '{255, 255, 255, 255});
        run_block("max", 1'b0, 1'b0);
    endtask

    task automatic test_mixed();
        fill_uniform('{100, 100, 100, 100}, '{110, 95, 100, 90});
        run_block("mixed", 1'b0, 1'b0);
    endtask

    task automatic test_keep();
        fill_uniform('{200, 200, 200, 200}, '{60, 60, 60, 60});
        for (int k = 0; k < LANES; k++) b_crt[0][k] = 50;
        for (int b = 1; b < BLK_PIX; b++) b_keep[b] = 1'b1;
        run_block("keep", 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        // beats offered while idle are not accepted and change nothing
        for (int c = 0; c < 3; c++) begin
            in_valid_i  = 1'b1;
            crt_keep    = 1'b0;
            crt_pixel_i = $urandom;
            pre_pixel_i = $urandom;
            @(posedge clk); #1;
            checks++;
            if (in_ready_o !== 1'b0 || busy_o !== 1'b0 ||
                crt_pixel_o[0 +: PIX_W] !== PIX_W'(m_crt[0])) begin
                errors++;
                $display("FAIL idle_ignore: ready=%b busy=%b crt0=%0d, expected 0 0 %0d",
                         in_ready_o, busy_o, crt_pixel_o[0 +: PIX_W], m_crt[0]);
            end
        end
        in_valid_i = 1'b0;
        fill_uniform('{100, 100, 100, 100}, '{110, 95, 100, 90});
        run_block("gaps", 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int pulses;
        fill_uniform('{0, 0, 0, 0}, '{255, 255, 255, 255});
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            in_valid_i  = 1'b1;
            crt_keep    = 1'b0;
            crt_pixel_i = $urandom;
            pre_pixel_i = $urandom;
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < LANES; k++) m_crt[k] = 0;
        check_all_zero("reset_mid");
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (sad_valid_o === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_pulse: pulses=%0d busy=%b, expected 0 0", pulses, busy_o);
        end
        run_block("after_reset", 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++) begin
            for (int b = 0; b < BLK_PIX; b++) begin
                b_keep[b] = (b == 0 && n == 0) ? 1'b0 : 1'($urandom_range(0, 2) == 0);
                for (int k = 0; k < LANES; k++) begin
                    b_crt[b][k] = $urandom_range(0, 255);
                    b_pre[b][k] = $urandom_range(0, 255);
                end
            end
            run_block("random", 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        in_valid_i  = 1'b0;
        crt_keep    = 1'b0;
        crt_pixel_i = '0;
        pre_pixel_i = '0;
        test_reset();
        test_max();
        test_mixed();
        test_keep();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
